amdc_adc_spi_emulator: RTL and testbench
========================================

Name: amdc_adc_spi_emulator

Overview:
Responder-side emulator of the AD4011 eddy-current ADC serial interface, used for hardware-in-the-loop testing of the sensor SPI master without a Kaman probe. It watches cnv and sclk from the master, snapshots two supplied sample words at conversion start, and shifts them MSB-first on miso_x/miso_y. It runs on the 200 MHz AXI clock and oversamples the master's sclk, which is 10 MHz or slower.

Parameters:
DATA_W, 18, sample word width in bits.
CONV_MIN, 64, minimum cnv-high time in clk cycles; shorter pulses are flagged.
SYNC_STAGES, 2, synchronizer depth on the cnv and sclk inputs (2 or 3).

Ports:
clk  in  1  AXI clock, 200 MHz.
rst_n  in  1  asynchronous active-low reset.
cnv  in  1  conversion strobe from the master; asynchronous.
sclk  in  1  serial clock from the master; asynchronous, idles low.
data_x  in  DATA_W  X-axis sample to transmit.
data_y  in  DATA_W  Y-axis sample to transmit.
pattern_sel  in  1  selects the ramp source; used only when TEST_PATTERN_EN is defined.
miso_x  out  1  X serial data.
miso_y  out  1  Y serial data.
busy  out  1  high while in state CONV or SHIFT.
frame_done  out  1  one-cycle pulse after DATA_W bits have been shifted.
err_short_cnv  out  1  sticky flag; cnv-high time was below CONV_MIN.
err_abort  out  1  sticky flag; cnv rose before the frame completed.
err_clr  in  1  synchronous clear of both sticky flags.

Behaviour:
Reset: all outputs are 0, the FSM is in IDLE, and the shift registers and counters are 0.

Input conditioning:
- cnv and sclk each pass through SYNC_STAGES flops.
- An edge-detect register follows, producing cnv_rise, cnv_fall and sclk_fall as one-cycle pulses.
- Latency from an input edge to its pulse is SYNC_STAGES+1 clk cycles.

State IDLE:
- miso outputs are 0.
- On cnv_rise: load shift_x/shift_y from data_x/data_y, clear conv_cnt, go to CONV.

State CONV:
- conv_cnt counts up and saturates at 255.
- On cnv_fall: if conv_cnt < CONV_MIN, set err_short_cnv; data is still shifted either way. Clear bit_cnt, go to SHIFT.

State SHIFT:
- miso_x/miso_y are registered copies of shift_x[DATA_W-1]/shift_y[DATA_W-1]. The MSB appears one cycle after entering SHIFT.
- On each sclk_fall: shift left one bit, fill the LSB with 0, increment bit_cnt.
- The master samples bit k after the k-th sclk falling edge plus its own delay. The emulator's shift lands SYNC_STAGES+2 cycles after that edge, so the previous bit stays stable through the master's sampling point.
- When bit_cnt reaches DATA_W and that cycle's shift completes: pulse frame_done, go to IDLE. miso returns to 0.
- cnv_rise while in SHIFT: set err_abort, reload the shift registers, clear conv_cnt, go to CONV. No frame_done is issued.

Other conditions:
- sclk_fall in IDLE or CONV is ignored. This covers surplus clocks beyond DATA_W; miso stays 0.
- cnv_rise and sclk_fall in the same cycle: cnv_rise wins.
- err_clr takes priority over a flag set in the same cycle.
- data_x/data_y are sampled only at the cnv_rise load. Later changes do not affect a frame in flight.
- Reset asserted mid-frame returns everything to the reset state immediately.

Optional Feature:
TEST_PATTERN_EN
- Defined: an 18-bit ramp register, reset to 0, increments by 1 on every frame_done and wraps at 2^DATA_W-1 to 0. When pattern_sel=1 at the cnv_rise load:
  - shift_x loads the ramp value;
  - shift_y loads its bitwise complement.
- Not defined: pattern_sel is ignored, no ramp logic is built, and data_x/data_y are always loaded.

Test Plan:
1. Nominal frame: data_x=18'h2A5A5, data_y=18'h15A5A, cnv high 64 cycles, then 18 sclk periods of 20 cycles -> the master-side capture equals both words; one frame_done; no error flags.
2. Short conversion: cnv high 20 cycles, then a full frame -> err_short_cnv=1, data still shifted correctly; err_clr pulse -> flag returns to 0.
3. Abort: cnv rises again after 7 sclk falls -> err_abort=1; no frame_done; the next full frame returns the newly loaded data_x=18'h00001 intact.
4. Surplus clocks: 22 sclk periods after cnv falls -> exactly one frame_done, after the 18th fall; miso=0 for the last 4 bits.
5. Reset mid-SHIFT after 9 bits -> all outputs 0 immediately; the next frame returns correct data with no error flags.
6. With TEST_PATTERN_EN defined and pattern_sel=1, three frames -> X captures 0, 1, 2; Y captures 18'h3FFFF, 18'h3FFFE, 18'h3FFFD.

Source files
------------

// File: rtl/amdc_adc_spi_emulator.sv
// Responder-side AD4011 serial interface emulator: snapshots X/Y samples on cnv and shifts them
// MSB-first on sclk falls. Optional ramp source is built when TEST_PATTERN_EN is defined.
module amdc_adc_spi_emulator #(
  parameter int unsigned DATA_W      = 18,
  parameter int unsigned CONV_MIN    = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cnv,
  input  logic              sclk,
  input  logic [DATA_W-1:0] data_x,
  input  logic [DATA_W-1:0] data_y,
  input  logic              pattern_sel,
  output logic              miso_x,
  output logic              miso_y,
  output logic              busy,
  output logic              frame_done,
  output logic              err_short_cnv,
  output logic              err_abort,
  input  logic              err_clr
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StConv, StShift} state_e;

  logic [SYNC_STAGES-1:0] cnv_sync_q, sclk_sync_q;
  logic                   cnv_prev_q, sclk_prev_q;
  logic                   cnv_rise, cnv_fall, sclk_fall;

  state_e            state_q;
  logic [DATA_W-1:0] shift_x_q, shift_y_q;
  logic [7:0]        conv_cnt_q, conv_cnt_inc;
  logic [CntW-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] load_x, load_y;
  logic              frame_end, short_cnv;

  // Synchronizers plus registered edge pulses: input edge to pulse is SYNC_STAGES+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnv_sync_q  <= '0;
      sclk_sync_q <= '0;
      cnv_prev_q  <= 1'b0;
      sclk_prev_q <= 1'b0;
      cnv_rise    <= 1'b0;
      cnv_fall    <= 1'b0;
      sclk_fall   <= 1'b0;
    end else begin
      cnv_sync_q  <= {cnv_sync_q[SYNC_STAGES-2:0], cnv};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cnv_prev_q  <= cnv_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cnv_rise    <= cnv_sync_q[SYNC_STAGES-1] & ~cnv_prev_q;
      cnv_fall    <= ~cnv_sync_q[SYNC_STAGES-1] & cnv_prev_q;
      sclk_fall   <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
    end
  end

  assign conv_cnt_inc = (conv_cnt_q == 8'hff) ? 8'hff : conv_cnt_q + 8'd1;
  // The fall cycle itself counts toward the high time, hence the incremented value.
  assign short_cnv    = ({24'd0, conv_cnt_inc} < CONV_MIN);
  assign frame_end    = (state_q == StShift) && !cnv_rise && sclk_fall &&
                        (bit_cnt_q == CntW'(DATA_W - 1));

`ifdef TEST_PATTERN_EN
  logic [DATA_W-1:0] ramp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_q <= '0;
    end else if (frame_end) begin
      ramp_q <= ramp_q + DATA_W'(1);
    end
  end

  assign load_x = pattern_sel ? ramp_q : data_x;
  assign load_y = pattern_sel ? ~ramp_q : data_y;
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign load_x = data_x;
  assign load_y = data_y;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      shift_x_q     <= '0;
      shift_y_q     <= '0;
      conv_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      miso_x        <= 1'b0;
      miso_y        <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      err_short_cnv <= 1'b0;
      err_abort     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          miso_x <= 1'b0;
          miso_y <= 1'b0;
          if (cnv_rise) begin
            shift_x_q  <= load_x;
            shift_y_q  <= load_y;
            conv_cnt_q <= '0;
            busy       <= 1'b1;
            state_q    <= StConv;
          end
        end
        StConv: begin
          miso_x     <= 1'b0;
          miso_y     <= 1'b0;
          conv_cnt_q <= conv_cnt_inc;
          if (cnv_fall) begin
            if (short_cnv) err_short_cnv <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= StShift;
          end
        end
        StShift: begin
          miso_x <= shift_x_q[DATA_W-1];
          miso_y <= shift_y_q[DATA_W-1];
          if (cnv_rise) begin
            err_abort  <= 1'b1;
            shift_x_q  <= load_x;
            shift_y_q  <= load_y;
            conv_cnt_q <= '0;
            state_q    <= StConv;
          end else if (sclk_fall) begin
            shift_x_q <= {shift_x_q[DATA_W-2:0], 1'b0};
            shift_y_q <= {shift_y_q[DATA_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + CntW'(1);
            if (frame_end) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state_q    <= StIdle;
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
      if (err_clr) begin
        err_short_cnv <= 1'b0;
        err_abort     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_amdc_adc_spi_emulator.sv
// Directed bench for amdc_adc_spi_emulator: an SPI master model drives cnv/sclk and captures
// miso; expected words and flags are hand-computed constants.
`timescale 1ns/1ps
module tb_amdc_adc_spi_emulator;

  localparam int unsigned DATA_W = 18;

  logic              clk, rst_n, cnv, sclk, pattern_sel, err_clr;
  logic [DATA_W-1:0] data_x, data_y;
  logic              miso_x, miso_y, busy, frame_done, err_short_cnv, err_abort;

  amdc_adc_spi_emulator #(
    .DATA_W      (DATA_W),
    .CONV_MIN    (64),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cnv           (cnv),
    .sclk          (sclk),
    .data_x        (data_x),
    .data_y        (data_y),
    .pattern_sel   (pattern_sel),
    .miso_x        (miso_x),
    .miso_y        (miso_y),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_short_cnv (err_short_cnv),
    .err_abort     (err_abort),
    .err_clr       (err_clr)
  );

  initial clk = 1'b0;
  always #2.5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  int fd_total   = 0;
  int fd_at_fall = -1;
  int cur_fall   = 0;
  int fd_base;

  logic [DATA_W-1:0] cap_x, cap_y;
  logic              tail_or, busy_mid;

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_total   = fd_total + 1;
      fd_at_fall = cur_fall;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master model: bit 0 captured before any sclk, bit k captured 10 cycles after fall k.
  task automatic run_frame(input int hi, input int nper);
    cur_fall = 0;
    cap_x    = '0;
    cap_y    = '0;
    tail_or  = 1'b0;
    @(negedge clk);
    cnv = 1'b1;
    cycles(hi);
    cnv = 1'b0;
    cycles(20);
    cap_x[DATA_W-1] = miso_x;
    cap_y[DATA_W-1] = miso_y;
    busy_mid        = busy;
    for (int k = 1; k <= nper; k++) begin
      sclk = 1'b1;
      cycles(10);
      sclk     = 1'b0;
      cur_fall = k;
      cycles(10);
      if (k < DATA_W) begin
        cap_x[DATA_W-1-k] = miso_x;
        cap_y[DATA_W-1-k] = miso_y;
      end else begin
        tail_or = tail_or | miso_x | miso_y;
      end
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    cycles(1);
  endtask

  initial begin
    rst_n = 1'b0; cnv = 1'b0; sclk = 1'b0; pattern_sel = 1'b0; err_clr = 1'b0;
    data_x = '0; data_y = '0;
    cycles(3);
    check("rst_miso_x", miso_x, 0);
    check("rst_miso_y", miso_y, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_short", err_short_cnv, 0);
    check("rst_err_abort", err_abort, 0);
    rst_n = 1'b1;
    cycles(2);

    // Nominal frame, cnv high exactly CONV_MIN
    data_x = 18'h2A5A5; data_y = 18'h15A5A; fd_base = fd_total;
    run_frame(64, 18);
    cycles(10);
    check("t1_x", cap_x, 18'h2A5A5);
    check("t1_y", cap_y, 18'h15A5A);
    check("t1_busy_mid", busy_mid, 1);
    check("t1_busy_end", busy, 0);
    check("t1_fd_cnt", fd_total - fd_base, 1);
    check("t1_fd_at", fd_at_fall, 18);
    check("t1_short", err_short_cnv, 0);
    check("t1_abort", err_abort, 0);

    // One cycle short of CONV_MIN
    run_frame(63, 18);
    cycles(10);
    check("t1b_short", err_short_cnv, 1);
    check("t1b_x", cap_x, 18'h2A5A5);
    pulse_clr();
    check("t1b_clr", err_short_cnv, 0);

    // Short conversion
    data_x = 18'h0F0F3; data_y = 18'h30C0C; fd_base = fd_total;
    run_frame(20, 18);
    cycles(10);
    check("t2_short", err_short_cnv, 1);
    check("t2_x", cap_x, 18'h0F0F3);
    check("t2_y", cap_y, 18'h30C0C);
    check("t2_fd_cnt", fd_total - fd_base, 1);
    pulse_clr();
    check("t2_clr", err_short_cnv, 0);

    // Abort after 7 falls, then a full frame with new data
    data_x = 18'h2A5A5; data_y = 18'h15A5A; fd_base = fd_total;
    run_frame(64, 7);
    check("t3_no_fd", fd_total - fd_base, 0);
    data_x = 18'h00001; data_y = 18'h3FFFE;
    run_frame(64, 18);
    cycles(10);
    check("t3_abort", err_abort, 1);
    check("t3_x", cap_x, 18'h00001);
    check("t3_y", cap_y, 18'h3FFFE);
    check("t3_fd_cnt", fd_total - fd_base, 1);
    check("t3_short", err_short_cnv, 0);
    pulse_clr();
    check("t3_clr", err_abort, 0);

    // Surplus clocks
    data_x = 18'h12345; data_y = 18'h2BCDE; fd_base = fd_total;
    run_frame(64, 22);
    cycles(10);
    check("t4_x", cap_x, 18'h12345);
    check("t4_y", cap_y, 18'h2BCDE);
    check("t4_fd_cnt", fd_total - fd_base, 1);
    check("t4_fd_at", fd_at_fall, 18);
    check("t4_tail", tail_or, 0);

    // Reset mid-SHIFT after 9 bits
    data_x = 18'h3FFFF; data_y = 18'h3FFFF;
    run_frame(64, 9);
    check("t5_pre_miso", miso_x, 1);
    rst_n = 1'b0;
    #1;
    check("t5_miso_x", miso_x, 0);
    check("t5_miso_y", miso_y, 0);
    check("t5_busy", busy, 0);
    check("t5_fd", frame_done, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    data_x = 18'h1F00F; data_y = 18'h00FF0; fd_base = fd_total;
    run_frame(64, 18);
    cycles(10);
    check("t5_x", cap_x, 18'h1F00F);
    check("t5_y", cap_y, 18'h00FF0);
    check("t5_fd_cnt", fd_total - fd_base, 1);
    check("t5_short", err_short_cnv, 0);
    check("t5_abort", err_abort, 0);

`ifdef TEST_PATTERN_EN
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    data_x = 18'h15555; data_y = 18'h0AAAA; pattern_sel = 1'b1;
    run_frame(64, 18);
    cycles(10);
    check("t6_x0", cap_x, 18'h00000);
    check("t6_y0", cap_y, 18'h3FFFF);
    run_frame(64, 18);
    cycles(10);
    check("t6_x1", cap_x, 18'h00001);
    check("t6_y1", cap_y, 18'h3FFFE);
    run_frame(64, 18);
    cycles(10);
    check("t6_x2", cap_x, 18'h00002);
    check("t6_y2", cap_y, 18'h3FFFD);
    pattern_sel = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
